// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into instruction-memory word writes
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;
  state_t      state, state_n;
  logic [15:0] n, n_hdr;
  logic [23:0] lanes;
  logic [1:0]  idx;
  logic        xfer, can_start;
  assign byte_ready = state inside {HDR0, HDR1, DATA};
  assign we         = state == WRITE;
  assign busy       = byte_ready | we;
  assign done       = state == DONE;
  assign err        = state == ERR;
  assign cpu_hold   = busy | err;
  assign xfer       = byte_valid & byte_ready;
  assign can_start  = start & (state inside {IDLE, DONE, ERR});
  assign n_hdr      = {byte_data, n[7:0]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: state_n = can_start ? HDR0 : state;
      HDR0:  state_n = xfer ? HDR1 : HDR0;
      HDR1:  state_n = !xfer ? HDR1 : n_hdr == 16'd0 ? DONE : n_hdr > 16'(DEPTH) ? ERR : DATA;
      DATA:  state_n = xfer && idx == 2'd3 ? WRITE : DATA;
      WRITE: state_n = word_count + 16'd1 == n ? DONE : DATA;
      default: state_n = IDLE;
    endcase
  end
  // lanes is a shift register: after three bytes it holds {b2,b1,b0}, the fourth byte tops off wd
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n          <= '0;
      lanes      <= '0;
      idx        <= '0;
      wa         <= '0;
      wd         <= '0;
      word_count <= '0;
    end else begin
      state <= state_n;
      if (can_start) word_count <= '0;
      if (we) word_count <= word_count + 16'd1;
      if (xfer && state == HDR0) n[7:0] <= byte_data;
      if (xfer && state == HDR1) begin
        n[15:8] <= byte_data;
        idx     <= '0;
      end
      if (xfer && state == DATA) begin
        idx   <= idx + 2'd1;
        lanes <= {byte_data, lanes[23:8]};
        if (idx == 2'd3) begin
          wd <= {byte_data, lanes};
          wa <= BASE_ADDR + {14'b0, word_count, 2'b00};
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for the instruction-memory loader with a write monitor
module tb_imem_loader;
  logic        clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, we, busy, done, err, cpu_hold;
  logic [31:0] wa, wd;
  logic [15:0] word_count;
  int          checks = 0, errors = 0;
  logic [31:0] wa_q[$], wd_q[$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .we(we), .wa(wa), .wd(wd), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we) begin
    wa_q.push_back(wa);
    wd_q.push_back(wd);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    byte_valid = 0;
    repeat (gap) @(negedge clk);
    byte_valid = 1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL send_byte: byte_ready=%b after %0d cycles, required 1", byte_ready, t);
    end
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!done && !err && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(done || err)) begin
      errors++;
      $display("FAIL wait_end: done=%b err=%b, required completion within 50 cycles", done, err);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, we, wa, wd, word_count, busy, done, err, cpu_hold} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b we=%b wa=%h wd=%h wc=%0d busy=%b done=%b err=%b hold=%b, required all 0",
               byte_ready, we, wa, wd, word_count, busy, done, err, cpu_hold);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] s[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h05, 8'h10, 8'h81, 8'hE2};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i], 0);
      if (i == 1) begin
        checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_hold: cpu_hold=%b busy=%b, required 1 1", cpu_hold, busy);
        end
      end
      if (i == 5) begin
        checks++;
        if (we !== 1'b1 || wa !== 32'h0 || wd !== 32'hE3A00013) begin
          errors++;
          $display("FAIL basic_we_latency: we=%b wa=%h wd=%h, required 1 00000000 e3a00013", we, wa, wd);
        end
      end
    end
    wait_end();
    checks++;
    if (wa_q.size() !== 2) begin
      errors++;
      $display("FAIL basic_nwrites: got %0d, required 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hE3A00013 || wa_q[1] !== 32'h4 || wd_q[1] !== 32'hE2811005) begin
        errors++;
        $display("FAIL basic_writes: %h:%h %h:%h, required 00000000:e3a00013 00000004:e2811005",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (word_count !== 16'd2 || done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL basic_final: wc=%0d done=%b err=%b hold=%b, required 2 1 0 0", word_count, done, err, cpu_hold);
    end
    checks++;
    if (wa !== 32'h4 || wd !== 32'hE2811005 || we !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_wa_wd: we=%b wa=%h wd=%h, required 0 00000004 e2811005", we, wa, wd);
    end
  endtask

  task automatic test_zero();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b wc=%0d, required 1 0 0", done, busy, word_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_nwrites: got %0d, required 0", wa_q.size());
    end
  endtask

  task automatic test_err_recover();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h21, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || wa_q.size() !== 0) begin
      errors++;
      $display("FAIL err_state: err=%b hold=%b done=%b busy=%b writes=%0d, required 1 1 0 0 0",
               err, cpu_hold, done, busy, wa_q.size());
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 1);
    send_byte(8'h34, 0);
    send_byte(8'h12, 2);
    wait_end();
    checks++;
    if (wa_q.size() !== 1 || done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL err_recover: writes=%0d done=%b err=%b hold=%b, required 1 1 0 0", wa_q.size(), done, err, cpu_hold);
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL err_recover_write: %h:%h, required 00000000:12345678", wa_q[0], wd_q[0]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0]  s[128];
    logic [31:0] exp_wd;
    for (int j = 0; j < 128; j++) s[j] = 8'(j * 7 + 3);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h20, $urandom_range(0, 3));
    send_byte(8'h00, $urandom_range(0, 3));
    for (int j = 0; j < 128; j++) send_byte(s[j], $urandom_range(0, 3));
    wait_end();
    checks++;
    if (wa_q.size() !== 32 || word_count !== 16'd32 || done !== 1'b1) begin
      errors++;
      $display("FAIL gaps_count: writes=%0d wc=%0d done=%b, required 32 32 1", wa_q.size(), word_count, done);
    end else begin
      for (int k = 0; k < 32; k++) begin
        exp_wd = {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
        checks++;
        if (wa_q[k] !== 32'(4 * k) || wd_q[k] !== exp_wd) begin
          errors++;
          $display("FAIL gaps_word%0d: %h:%h, required %h:%h", k, wa_q[k], wd_q[k], 32'(4 * k), exp_wd);
        end
      end
      checks++;
      if (wa_q[31] !== 32'h7C) begin
        errors++;
        $display("FAIL gaps_last_wa: got %h, required 0000007c", wa_q[31]);
      end
    end
  endtask

  task automatic test_reset_midload();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({byte_ready, we, wa, wd, word_count, busy, done, err, cpu_hold} !== '0) begin
      errors++;
      $display("FAIL midload_reset_outputs: ready=%b we=%b wa=%h wd=%h wc=%0d busy=%b done=%b err=%b hold=%b, required all 0",
               byte_ready, we, wa, wd, word_count, busy, done, err, cpu_hold);
    end
    reset = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (wa_q.size() !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_no_write: writes=%0d busy=%b, required 1 0", wa_q.size(), busy);
    end
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    wait_end();
    checks++;
    if (wa_q.size() !== 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL midload_reload_count: writes=%0d done=%b, required 1 1", wa_q.size(), done);
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL midload_reload_write: %h:%h, required 00000000:deadbeef", wa_q[0], wd_q[0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    pulse_start();
    send_byte(8'hA3, 0);
    send_byte(8'hA4, 0);
    send_byte(8'hB1, 0);
    pulse_start();
    send_byte(8'hB2, 0);
    send_byte(8'hB3, 0);
    send_byte(8'hB4, 0);
    wait_end();
    checks++;
    if (wa_q.size() !== 2 || word_count !== 16'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_count: writes=%0d wc=%0d done=%b, required 2 2 1", wa_q.size(), word_count, done);
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hA4A3A2A1 || wa_q[1] !== 32'h4 || wd_q[1] !== 32'hB4B3B2B1) begin
        errors++;
        $display("FAIL start_ignored_writes: %h:%h %h:%h, required 00000000:a4a3a2a1 00000004:b4b3b2b1",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_err_recover();
    test_gaps();
    test_reset_midload();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
